key192_rk_store: RTL and testbench
==================================

Name: key192_rk_store

Overview:
- Round-key buffer sitting directly downstream of the AES-192 key expander (key192_exp).
- Captures the 13 round keys the expander emits on its rk192/rk192_count/rk192_le outputs.
- Serves them to the round-transformation datapath through a request/valid read port.
- The read port stalls on keys not yet produced, so encryption can overlap expansion.

Parameters:
- NK, 13: number of round keys stored (AES-192: Nr+1).
- KW, 128: round-key width in bits.
- IW, 4: round-index width.

Ports:
- mclk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- exp_start  in  1  same start pulse given to key192_exp; invalidates stored keys.
- rk192  in  [0:KW-1]  round key from expander.
- rk192_count  in  [IW-1:0]  round-key index from expander.
- rk192_le  in  1  load enable; rk192/rk192_count are valid this cycle.
- rd_req  in  1  read request, single-cycle pulse.
- rd_round  in  [IW-1:0]  requested round index, sampled with rd_req.
- rd_key  out  [0:KW-1]  returned round key.
- rd_valid  out  1  one-cycle pulse; rd_key is valid.
- rd_busy  out  1  high while a request waits for its key.
- rd_err  out  1  one-cycle pulse; rd_round > NK-1.
- wr_err  out  1  one-cycle pulse; rk192_le with rk192_count > NK-1.
- keys_ready  out  1  all NK keys valid.

Behaviour:
- Reset (async, arst_n=0):
  - vld[NK-1:0]=0, FSM=IDLE.
  - rd_key=0, rd_valid=0, rd_busy=0, rd_err=0, wr_err=0, keys_ready=0.
  - Key storage array is not reset.
- Write path:
  - rk192_le=1 and rk192_count<=12: mem[count]<=rk192 and vld[count]<=1 at the next edge.
  - count>12: nothing is stored and wr_err pulses the next cycle.
- Invalidation: vld_next = (exp_start ? 0 : vld) | (le-write bit). A write coinciding with exp_start therefore remains valid.
- keys_ready = &vld. It is decoded directly from the vld registers, so it rises the cycle after key 12 is written and drops the cycle after exp_start.
- FSM states IDLE and WAIT. Registered pending index p_round.
- IDLE:
  - rd_req with rd_round>12: rd_err pulses next cycle; stay in IDLE.
  - rd_req, rd_round<=12, and hit: next cycle rd_key=key and rd_valid=1 (latency 1). Hit means vld[rd_round]=1, or a same-cycle write with rk192_le=1 and count==rd_round.
  - On a same-cycle write to that index, the incoming rk192 is returned (write-first bypass).
  - rd_req, rd_round<=12, and no hit: p_round<=rd_round, go to WAIT, rd_busy=1 from the next cycle.
- WAIT:
  - rd_req is ignored: no response and no error.
  - When rk192_le=1 and rk192_count==p_round: next cycle rd_key=rk192, rd_valid=1, rd_busy=0, go to IDLE.
  - exp_start while in WAIT: stay in WAIT. The key will arrive from the new expansion.
- rd_key holds its last value when rd_valid=0. rd_valid is never high in consecutive cycles unless rd_req was consecutive in IDLE.
- Reset mid-operation (WAIT or partially filled): everything returns to reset values immediately; the pending request is dropped.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES192_NR=12, AES192_NK=13, AES_KW=128, RK_IW=4;
  - FSM state encoding {IDLE, WAIT}.
- Sub-module rk_regfile: NK x KW register array with one write port and one async read port, plus the vld bitmap, exp_start clear and keys_ready decode.
- The read FSM and bypass logic stay in key192_rk_store.

Test Plan:
- Full fill, FIPS-197 A.2 key:
  - Stimulus: exp_start with key 8E73B0F7_DA0E6452_C810F32B_809079E5_62F8EAD2_522C6B7B drives key192_exp; its outputs feed this block.
  - Required: keys_ready rises one cycle after index 12 is written.
  - Required: rd_round=0 returns 8e73b0f7da0e6452c810f32b809079e5 with latency 1.
  - Required: rd_round=1 returns 62f8ead2522c6b7bfe0c91f72402f5a5.
  - Required: rd_round=12 returns e98ba06f448c773c8ecc720401002202.
- Stall:
  - Stimulus: rd_req with rd_round=12 immediately after exp_start.
  - Required: rd_busy=1 until the expander writes index 12.
  - Required: rd_valid pulses exactly once, the cycle after that write, with e98ba06f448c773c8ecc720401002202.
  - Required: rd_req pulses during WAIT produce nothing.
- Bypass: rd_req with rd_round=5 in the same cycle as rk192_le with count=5 → next cycle rd_valid=1 and rd_key equals that rk192.
- Errors:
  - rd_round=13 → rd_err pulse, no rd_valid.
  - Forced rk192_le with count=15 → wr_err pulse, vld unchanged.
- Re-key:
  - Stimulus: after a full fill, assert exp_start.
  - Required: keys_ready=0 the next cycle; rd_round=3 stalls (rd_busy=1) until the new index 3 arrives.
  - Required: exp_start coincident with an le write to index 0 leaves vld[0]=1.
- Reset mid-WAIT: arst_n low for 1 ns while rd_busy=1 → rd_busy, rd_valid and keys_ready are 0 immediately; no rd_valid after release.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-192 round-key constants and the read-port FSM state encoding.
`timescale 1ns/1ps
package aes_pkg;
    localparam int AES192_NR = 12;
    localparam int AES192_NK = AES192_NR + 1;
    localparam int AES_KW = 128;
    localparam int RK_IW = 4;
    typedef enum logic {IDLE, WAIT} rd_state_t;
endpackage

// File: rtl/rk_regfile.sv
// rk_regfile: round-key array with one write port, one async read port,
// a valid bitmap cleared by a new expansion, and the all-keys-valid decode.
`timescale 1ns/1ps
module rk_regfile
    import aes_pkg::*;
#(
    parameter int NK = AES192_NK,
    parameter int KW = AES_KW,
    parameter int IW = RK_IW
) (
    input  logic          mclk,
    input  logic          arst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [0:KW-1] wdata,
    input  logic [IW-1:0] raddr,
    output logic [0:KW-1] rdata,
    output logic [NK-1:0] vld,
    output logic          keys_ready
);
    logic [0:KW-1] mem [NK];
    logic [NK-1:0] wbit;
    // A write landing together with a clear survives it.
    assign wbit = we ? NK'(1) << waddr : '0;
    assign rdata = mem[raddr];
    assign keys_ready = &vld;
    always_ff @(posedge mclk)
        if (we) mem[waddr] <= wdata;
    always_ff @(posedge mclk or negedge arst_n)
        if (!arst_n) vld <= '0;
        else vld <= (clr ? '0 : vld) | wbit;
endmodule

// File: rtl/key192_rk_store.sv
// key192_rk_store: buffers AES-192 round keys from the expander and serves them
// through a request/valid port that stalls on keys not yet produced.
`timescale 1ns/1ps
module key192_rk_store
    import aes_pkg::*;
#(
    parameter int NK = AES192_NK,
    parameter int KW = AES_KW,
    parameter int IW = RK_IW
) (
    input  logic          mclk,
    input  logic          arst_n,
    input  logic          exp_start,
    input  logic [0:KW-1] rk192,
    input  logic [IW-1:0] rk192_count,
    input  logic          rk192_le,
    input  logic          rd_req,
    input  logic [IW-1:0] rd_round,
    output logic [0:KW-1] rd_key,
    output logic          rd_valid,
    output logic          rd_busy,
    output logic          rd_err,
    output logic          wr_err,
    output logic          keys_ready
);
    rd_state_t     state;
    logic [IW-1:0] p_round;
    logic [NK-1:0] vld;
    logic [0:KW-1] rdata;
    logic          wr_ok, rd_ok, byp, hit;
    assign wr_ok = rk192_le && rk192_count <= IW'(NK-1);
    assign rd_ok = rd_round <= IW'(NK-1);
    assign byp = rk192_le && rk192_count == rd_round;
    assign hit = byp || (rd_ok && vld[rd_round]);
    rk_regfile #(.NK(NK), .KW(KW), .IW(IW)) u_regfile (
        .mclk(mclk),
        .arst_n(arst_n),
        .clr(exp_start),
        .we(wr_ok),
        .waddr(rk192_count),
        .wdata(rk192),
        .raddr(rd_round),
        .rdata(rdata),
        .vld(vld),
        .keys_ready(keys_ready)
    );
    // Requests arriving while WAIT is pending are dropped, not queued.
    always_ff @(posedge mclk or negedge arst_n)
        if (!arst_n) begin
            state    <= IDLE;
            p_round  <= '0;
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_busy  <= 1'b0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            wr_err   <= rk192_le && !wr_ok;
            if (state == IDLE) begin
                if (rd_req && !rd_ok) rd_err <= 1'b1;
                else if (rd_req && hit) begin
                    rd_key   <= byp ? rk192 : rdata;
                    rd_valid <= 1'b1;
                end else if (rd_req) begin
                    p_round <= rd_round;
                    rd_busy <= 1'b1;
                    state   <= WAIT;
                end
            end else if (rk192_le && rk192_count == p_round) begin
                rd_key   <= rk192;
                rd_valid <= 1'b1;
                rd_busy  <= 1'b0;
                state    <= IDLE;
            end
        end
endmodule

// File: tb/tb_key192_rk_store.sv
// tb_key192_rk_store: randomized scenarios checked against an AES-192 key
// schedule model and a simple store/valid model of the buffer.
`timescale 1ns/1ps
module tb_key192_rk_store;
    logic         mclk, arst_n, exp_start, rk192_le, rd_req;
    logic [0:127] rk192, rd_key;
    logic [3:0]   rk192_count, rd_round;
    logic         rd_valid, rd_busy, rd_err, wr_err, keys_ready;
    int           checks = 0, errors = 0;
    logic [0:127] ref_rk [13];
    logic [0:127] m_mem [13];
    logic [12:0]  m_vld;
    localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [0:127] K0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [0:127] K1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [0:127] K12 = 128'he98ba06f448c773c8ecc720401002202;

    key192_rk_store dut (
        .mclk(mclk), .arst_n(arst_n), .exp_start(exp_start), .rk192(rk192),
        .rk192_count(rk192_count), .rk192_le(rk192_le), .rd_req(rd_req),
        .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid), .rd_busy(rd_busy),
        .rd_err(rd_err), .wr_err(wr_err), .keys_ready(keys_ready)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gm(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [191:0] key);
        logic [31:0] w [52];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start();
        exp_start = 1'b1;
        m_vld = '0;
        step();
        exp_start = 1'b0;
    endtask

    task automatic emit(input int idx, input logic [0:127] d);
        rk192_le = 1'b1;
        rk192_count = idx[3:0];
        rk192 = d;
        step();
        rk192_le = 1'b0;
        if (idx < 13) begin
            m_mem[idx] = d;
            m_vld[idx] = 1'b1;
        end
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        arst_n = 1'b0; exp_start = 1'b0; rk192_le = 1'b0; rd_req = 1'b0;
        rk192 = '0; rk192_count = '0; rd_round = '0; m_vld = '0;
        repeat (2) @(posedge mclk);
        #1;
        checks++;
        if (rd_key !== '0) begin errors++; $display("FAIL reset_rd_key got %h exp 0", rd_key); end
        checks++;
        if ({rd_valid, rd_busy, rd_err, wr_err, keys_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got v%b b%b re%b we%b kr%b exp all 0", rd_valid, rd_busy, rd_err, wr_err, keys_ready);
        end
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_full_fill();
        logic [0:127] kc [3];
        int rs [3];
        int r;
        kc[0] = K0; kc[1] = K1; kc[2] = K12;
        rs[0] = 0; rs[1] = 1; rs[2] = 12;
        expand(FIPS_KEY);
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            idle($urandom_range(0, 2));
            emit(i, ref_rk[i]);
            checks++;
            if (keys_ready !== (&m_vld)) begin errors++; $display("FAIL fill_keys_ready idx%0d got %b exp %b", i, keys_ready, &m_vld); end
        end
        for (int k = 0; k < 3; k++) begin
            rd_req = 1'b1; rd_round = rs[k][3:0];
            step();
            rd_req = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_key !== kc[k]) begin
                errors++;
                $display("FAIL fips_read r%0d valid=%b got %h exp %h", rs[k], rd_valid, rd_key, kc[k]);
            end
            step();
        end
        for (int k = 0; k < 6; k++) begin
            r = $urandom_range(0, 12);
            rd_req = 1'b1; rd_round = r[3:0];
            step();
            rd_req = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_key !== ref_rk[r]) begin
                errors++;
                $display("FAIL rand_read r%0d valid=%b got %h exp %h", r, rd_valid, rd_key, ref_rk[r]);
            end
            step();
            checks++;
            if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_pulse r%0d valid got %b exp 0", r, rd_valid); end
        end
    endtask

    task automatic test_back_to_back();
        int r;
        for (int k = 0; k < 5; k++) begin
            r = $urandom_range(0, 12);
            rd_req = 1'b1; rd_round = r[3:0];
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_key !== m_mem[r]) begin
                errors++;
                $display("FAIL b2b_read k%0d r%0d valid=%b got %h exp %h", k, r, rd_valid, rd_key, m_mem[r]);
            end
        end
        rd_req = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end valid got %b exp 0", rd_valid); end
    endtask

    task automatic test_stall();
        int r;
        expand(FIPS_KEY);
        pulse_start();
        rd_req = 1'b1; rd_round = 4'd12;
        step();
        rd_req = 1'b0;
        checks++;
        if (rd_busy !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL stall_enter busy=%b valid=%b exp 1/0", rd_busy, rd_valid); end
        for (int i = 0; i < 13; i++) begin
            repeat ($urandom_range(0, 2)) begin
                r = $urandom_range(0, 15);
                rd_req = $urandom_range(0, 1) == 1; rd_round = r[3:0];
                step();
                rd_req = 1'b0;
                checks++;
                if ({rd_busy, rd_valid, rd_err} !== 3'b100) begin
                    errors++;
                    $display("FAIL stall_gap idx%0d got b%b v%b e%b exp b1 v0 e0", i, rd_busy, rd_valid, rd_err);
                end
            end
            r = $urandom_range(0, 15);
            rd_req = $urandom_range(0, 1) == 1; rd_round = r[3:0];
            emit(i, ref_rk[i]);
            rd_req = 1'b0;
            checks++;
            if (i < 12 && {rd_busy, rd_valid, rd_err} !== 3'b100) begin
                errors++;
                $display("FAIL stall_write idx%0d got b%b v%b e%b exp b1 v0 e0", i, rd_busy, rd_valid, rd_err);
            end else if (i == 12 && (rd_busy !== 1'b0 || rd_valid !== 1'b1 || rd_key !== K12)) begin
                errors++;
                $display("FAIL stall_release got b%b v%b %h exp b0 v1 %h", rd_busy, rd_valid, rd_key, K12);
            end
        end
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin errors++; $display("FAIL stall_once valid=%b busy=%b exp 0/0", rd_valid, rd_busy); end
    endtask

    task automatic test_bypass();
        logic [0:127] d;
        pulse_start();
        for (int i = 0; i < 5; i++) emit(i, ref_rk[i]);
        d = rnd128();
        rd_req = 1'b1; rd_round = 4'd5;
        emit(5, d);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_busy !== 1'b0 || rd_key !== d) begin
            errors++;
            $display("FAIL bypass_new valid=%b busy=%b got %h exp %h", rd_valid, rd_busy, rd_key, d);
        end
        step();
        d = rnd128();
        rd_req = 1'b1; rd_round = 4'd2;
        emit(2, d);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_key !== d) begin
            errors++;
            $display("FAIL bypass_overwrite valid=%b got %h exp %h", rd_valid, rd_key, d);
        end
        step();
    endtask

    task automatic test_errors();
        int r;
        for (int k = 0; k < 3; k++) begin
            r = 13 + $urandom_range(0, 2);
            rd_req = 1'b1; rd_round = r[3:0];
            step();
            rd_req = 1'b0;
            checks++;
            if ({rd_err, rd_valid, rd_busy} !== 3'b100) begin
                errors++;
                $display("FAIL rd_err r%0d got e%b v%b b%b exp e1 v0 b0", r, rd_err, rd_valid, rd_busy);
            end
            step();
            checks++;
            if (rd_err !== 1'b0) begin errors++; $display("FAIL rd_err_pulse got %b exp 0", rd_err); end
        end
        r = (k_sel() == 0) ? 15 : 13;
        emit(r, rnd128());
        checks++;
        if (wr_err !== 1'b1 || keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_err c%0d got we%b kr%b exp we1 kr0", r, wr_err, keys_ready);
        end
        step();
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse got %b exp 0", wr_err); end
        for (int i = 6; i < 13; i++) begin
            emit(i, ref_rk[i]);
            checks++;
            if (keys_ready !== (&m_vld)) begin errors++; $display("FAIL err_fill_kr idx%0d got %b exp %b", i, keys_ready, &m_vld); end
        end
        for (int i = 0; i < 13; i++) begin
            rd_req = 1'b1; rd_round = i[3:0];
            step();
            rd_req = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_key !== m_mem[i]) begin
                errors++;
                $display("FAIL stored_read r%0d valid=%b got %h exp %h", i, rd_valid, rd_key, m_mem[i]);
            end
        end
        step();
    endtask

    function automatic int k_sel();
        return $urandom_range(0, 1);
    endfunction

    task automatic test_rekey();
        expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        exp_start = 1'b1;
        m_vld = '0;
        emit(0, ref_rk[0]);
        exp_start = 1'b0;
        checks++;
        if (keys_ready !== 1'b0) begin errors++; $display("FAIL rekey_kr got %b exp 0", keys_ready); end
        rd_req = 1'b1; rd_round = 4'd0;
        step();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_key !== ref_rk[0]) begin
            errors++;
            $display("FAIL rekey_keep0 valid=%b got %h exp %h", rd_valid, rd_key, ref_rk[0]);
        end
        rd_req = 1'b1; rd_round = 4'd3;
        step();
        rd_req = 1'b0;
        checks++;
        if (rd_busy !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rekey_stall busy=%b valid=%b exp 1/0", rd_busy, rd_valid); end
        for (int i = 1; i < 13; i++) begin
            idle($urandom_range(0, 1));
            emit(i, ref_rk[i]);
            checks++;
            if (i < 3 && (rd_busy !== 1'b1 || rd_valid !== 1'b0)) begin
                errors++;
                $display("FAIL rekey_wait idx%0d busy=%b valid=%b exp 1/0", i, rd_busy, rd_valid);
            end else if (i == 3 && (rd_busy !== 1'b0 || rd_valid !== 1'b1 || rd_key !== ref_rk[3])) begin
                errors++;
                $display("FAIL rekey_release busy=%b valid=%b got %h exp %h", rd_busy, rd_valid, rd_key, ref_rk[3]);
            end else if (i > 3 && (rd_valid !== 1'b0 || keys_ready !== (&m_vld))) begin
                errors++;
                $display("FAIL rekey_tail idx%0d valid=%b kr=%b exp 0/%b", i, rd_valid, keys_ready, &m_vld);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        checks++;
        if (keys_ready !== 1'b1) begin errors++; $display("FAIL pre_reset_kr got %b exp 1", keys_ready); end
        pulse_start();
        emit(0, ref_rk[0]);
        emit(1, ref_rk[1]);
        rd_req = 1'b1; rd_round = 4'd9;
        step();
        rd_req = 1'b0;
        checks++;
        if (rd_busy !== 1'b1) begin errors++; $display("FAIL mid_wait_busy got %b exp 1", rd_busy); end
        #2 arst_n = 1'b0;
        #0.5;
        checks++;
        if ({rd_busy, rd_valid, keys_ready} !== 3'b000 || rd_key !== '0) begin
            errors++;
            $display("FAIL async_reset got b%b v%b kr%b key %h exp all 0", rd_busy, rd_valid, keys_ready, rd_key);
        end
        #0.5 arst_n = 1'b1;
        m_vld = '0;
        step();
        for (int i = 2; i < 13; i++) begin
            emit(i, ref_rk[i]);
            checks++;
            if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
                errors++;
                $display("FAIL dropped_req idx%0d valid=%b busy=%b exp 0/0", i, rd_valid, rd_busy);
            end
        end
        checks++;
        if (keys_ready !== 1'b0) begin errors++; $display("FAIL post_reset_kr got %b exp 0", keys_ready); end
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_back_to_back();
        test_stall();
        test_bypass();
        test_errors();
        test_rekey();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
